rename_ctrl: RTL and testbench

Rename-stage controller that owns the frontend RAT's single write port and the physical-register free list. After reset, it initialises the RAT to the identity map. It then allocates physical registers to renaming instructions and recycles registers released at commit. On a flush, it restores the frontend RAT from the retirement RAT mapping and rewinds the free list.

---
 rtl/rename_ctrl.sv | 155 +++++++++++++++
 tb/tb_rename_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ctrl.sv
// Rename-stage controller: owns the frontend RAT write port and the physical-register free list.
// Walks the RAT (identity after reset, retirement copy after a flush) one write per two cycles.
module rename_ctrl #(
    parameter int NUM_ARCH_REGS = 35,
    parameter int NUM_PHYS_REGS = 64,
    localparam int LA = $clog2(NUM_ARCH_REGS),
    localparam int LP = $clog2(NUM_PHYS_REGS)
) (
    input  logic                        i_CLK,
    input  logic                        i_RESET,
    input  logic                        i_REN_VALID,
    input  logic [LA-1:0]               i_REN_AREG,
    output logic                        o_REN_READY,
    output logic [LP-1:0]               o_REN_PREG,
    output logic [LP-1:0]               o_REN_OLD_PREG,
    input  logic                        i_COMMIT_VALID,
    input  logic [LP-1:0]               i_COMMIT_FREE_PREG,
    input  logic                        i_FLUSH,
    input  logic [NUM_ARCH_REGS*LP-1:0] i_FRAT_MAP,
    input  logic [NUM_ARCH_REGS*LP-1:0] i_RRAT_MAP,
    output logic [LA-1:0]               o_RAT_SRC,
    output logic [LP-1:0]               o_RAT_DST,
    output logic                        o_RAT_WRITE
);

    localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PW = $clog2(FL_DEPTH);
    localparam int CW = $clog2(FL_DEPTH + 1);
    localparam int WW = $clog2(NUM_ARCH_REGS + 1);
    localparam logic [CW-1:0] FULL = CW'(FL_DEPTH);
    localparam logic [WW-1:0] WALK_END = WW'(NUM_ARCH_REGS);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_RECOVER} state_t;

    state_t          r_state, w_state_nxt;
    logic [WW-1:0]   r_walk, w_walk_nxt;
    logic            r_gap, w_gap_nxt;
    logic            r_rat_write, w_wr_nxt;
    logic [LA-1:0]   r_rat_src, w_src_nxt;
    logic [LP-1:0]   r_rat_dst, w_dst_nxt;

    logic [LP-1:0]   r_fl [FL_DEPTH];
    logic [PW-1:0]   r_head, r_rhead, r_tail;
    logic [CW-1:0]   r_count;

    logic            w_ready, w_accept, w_flush, w_commit;
    logic [LP-1:0]   w_rrat_walk, w_old_preg;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_ready  = (r_state == S_RUN) && !r_gap && (r_count != '0) && !i_FLUSH;
    assign w_accept = i_REN_VALID && w_ready;
    assign w_flush  = i_FLUSH && (r_state != S_INIT);
    assign w_commit = i_COMMIT_VALID &&
                      ((r_state == S_RECOVER) || ((r_state == S_RUN) && (r_count != FULL)));

    always_comb begin
        w_rrat_walk = '0;
        w_old_preg  = '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            if (r_walk == WW'(i))     w_rrat_walk = i_RRAT_MAP[i*LP +: LP];
            if (i_REN_AREG == LA'(i)) w_old_preg  = i_FRAT_MAP[i*LP +: LP];
        end
    end

    assign o_REN_READY    = w_ready;
    assign o_REN_PREG     = r_fl[r_head];
    assign o_REN_OLD_PREG = w_old_preg;
    assign o_RAT_WRITE    = r_rat_write;
    assign o_RAT_SRC      = r_rat_src;
    assign o_RAT_DST      = r_rat_dst;

    always_comb begin
        w_state_nxt = r_state;
        w_walk_nxt  = r_walk;
        w_gap_nxt   = r_gap;
        w_wr_nxt    = 1'b0;
        w_src_nxt   = r_rat_src;
        w_dst_nxt   = r_rat_dst;
        if (w_flush) begin
            w_state_nxt = S_RECOVER;
            w_walk_nxt  = '0;
            w_gap_nxt   = 1'b0;
        end else if (r_state == S_RUN) begin
            w_gap_nxt = w_accept;
            if (w_accept) begin
                w_wr_nxt  = 1'b1;
                w_src_nxt = i_REN_AREG;
                w_dst_nxt = r_fl[r_head];
            end
        end else if (r_gap) begin
            // The low cycle after the last walk write is where the walk hands over to RUN.
            w_gap_nxt = 1'b0;
            if (r_walk == WALK_END) w_state_nxt = S_RUN;
        end else if (r_walk != WALK_END) begin
            w_wr_nxt   = 1'b1;
            w_src_nxt  = LA'(r_walk);
            w_dst_nxt  = (r_state == S_INIT) ? LP'(r_walk) : w_rrat_walk;
            w_walk_nxt = r_walk + 1'b1;
            w_gap_nxt  = 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            r_state     <= S_INIT;
            r_walk      <= '0;
            r_gap       <= 1'b0;
            r_rat_write <= 1'b0;
            r_rat_src   <= '0;
            r_rat_dst   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_walk      <= w_walk_nxt;
            r_gap       <= w_gap_nxt;
            r_rat_write <= w_wr_nxt;
            r_rat_src   <= w_src_nxt;
            r_rat_dst   <= w_dst_nxt;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            for (int k = 0; k < FL_DEPTH; k++) r_fl[k] <= LP'(NUM_ARCH_REGS + k);
            r_head  <= '0;
            r_rhead <= '0;
            r_tail  <= '0;
            r_count <= FULL;
        end else begin
            if (w_commit) begin
                r_fl[r_tail] <= i_COMMIT_FREE_PREG;
                r_tail       <= ptr_inc(r_tail);
                r_rhead      <= ptr_inc(r_rhead);
            end
            // With nothing in flight, every register past the retire head is free again.
            if (w_flush || (r_state == S_RECOVER)) begin
                r_head  <= w_commit ? ptr_inc(r_rhead) : r_rhead;
                r_count <= FULL;
            end else if (r_state == S_RUN) begin
                if (w_accept) r_head <= ptr_inc(r_head);
                if (w_accept && !w_commit)      r_count <= r_count - 1'b1;
                else if (!w_accept && w_commit) r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET && i_COMMIT_VALID && (r_state == S_RUN))
            assert (r_count != FULL);
    end

endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl with a behavioural frontend RAT that latches each write pulse.
module tb_rename_ctrl;

    localparam int NA = 35;
    localparam int LP = 6;

    logic          clk;
    logic          rst_n;
    logic          ren_valid;
    logic [5:0]    ren_areg;
    logic          ren_ready;
    logic [5:0]    ren_preg;
    logic [5:0]    ren_old;
    logic          commit_valid;
    logic [5:0]    commit_preg;
    logic          flush;
    logic [NA*LP-1:0] frat_map;
    logic [NA*LP-1:0] rrat_map;
    logic [5:0]    rat_src;
    logic [5:0]    rat_dst;
    logic          rat_write;

    logic [5:0]    frat [NA];
    logic [5:0]    rrat [NA];
    int            n_vec;
    int            n_err;

    rename_ctrl dut (
        .i_CLK              (clk),
        .i_RESET            (rst_n),
        .i_REN_VALID        (ren_valid),
        .i_REN_AREG         (ren_areg),
        .o_REN_READY        (ren_ready),
        .o_REN_PREG         (ren_preg),
        .o_REN_OLD_PREG     (ren_old),
        .i_COMMIT_VALID     (commit_valid),
        .i_COMMIT_FREE_PREG (commit_preg),
        .i_FLUSH            (flush),
        .i_FRAT_MAP         (frat_map),
        .i_RRAT_MAP         (rrat_map),
        .o_RAT_SRC          (rat_src),
        .o_RAT_DST          (rat_dst),
        .o_RAT_WRITE        (rat_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rat_write && (rat_src < 6'(NA))) frat[rat_src] <= rat_dst;
    end

    always_comb begin
        for (int i = 0; i < NA; i++) begin
            frat_map[i*LP +: LP] = frat[i];
            rrat_map[i*LP +: LP] = rrat[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_init_walk(input string tag, input int flush_at);
        int   pulses;
        logic prev;
        pulses = 0;
        prev   = 1'b0;
        rst_n  = 1'b1;
        for (int e = 1; e <= 72; e++) begin
            flush = (e == flush_at);
            step();
            flush = 1'b0;
            #1;
            n_vec++;
            if ((e % 2 == 1) && (e <= 69)) begin
                if (rat_write !== 1'b1 || rat_src !== 6'((e-1)/2) || rat_dst !== 6'((e-1)/2)) begin
                    n_err++;
                    $display("FAIL %s_write edge %0d: got wr=%0b %0d->%0d want wr=1 %0d->%0d",
                             tag, e, rat_write, rat_src, rat_dst, (e-1)/2, (e-1)/2);
                end
            end else if (rat_write !== 1'b0) begin
                n_err++;
                $display("FAIL %s_idle edge %0d: got wr=%0b want 0", tag, e, rat_write);
            end
            n_vec++;
            if (ren_ready !== (e >= 70)) begin
                n_err++;
                $display("FAIL %s_ready edge %0d: got %0b want %0b", tag, e, ren_ready, e >= 70);
            end
            n_vec++;
            if (prev && rat_write) begin
                n_err++;
                $display("FAIL %s_consecutive edge %0d: got two high cycles want pulse", tag, e);
            end
            prev = rat_write;
            if (rat_write === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 35) begin
            n_err++;
            $display("FAIL %s_pulses: got %0d want 35", tag, pulses);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_vec++;
        if (rat_write !== 1'b0 || rat_src !== 6'd0 || rat_dst !== 6'd0 || ren_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got wr=%0b src=%0d dst=%0d rdy=%0b want 0 0 0 0",
                     rat_write, rat_src, rat_dst, ren_ready);
        end
        test_init_walk("init", 0);
    endtask

    task automatic test_drain();
        ren_valid = 1'b1;
        ren_areg  = 6'd5;
        for (int k = 0; k < 29; k++) begin
            #1;
            n_vec++;
            if (ren_ready !== 1'b1 || ren_preg !== 6'(35+k) || ren_old !== ((k == 0) ? 6'd5 : 6'(34+k))) begin
                n_err++;
                $display("FAIL drain_alloc %0d: got rdy=%0b preg=%0d old=%0d want 1 %0d %0d",
                         k, ren_ready, ren_preg, ren_old, 35+k, (k == 0) ? 5 : 34+k);
            end
            step();
            n_vec++;
            if (rat_write !== 1'b1 || rat_src !== 6'd5 || rat_dst !== 6'(35+k) || ren_ready !== 1'b0) begin
                n_err++;
                $display("FAIL drain_write %0d: got wr=%0b %0d->%0d rdy=%0b want 1 5->%0d 0",
                         k, rat_write, rat_src, rat_dst, ren_ready, 35+k);
            end
            step();
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (ren_ready !== 1'b0 || rat_write !== 1'b0) begin
                n_err++;
                $display("FAIL drain_empty %0d: got rdy=%0b wr=%0b want 0 0", c, ren_ready, rat_write);
            end
            step();
        end
        ren_valid = 1'b0;
    endtask

    task automatic test_recycle();
        commit_valid = 1'b1;
        commit_preg  = 6'd5;
        step();
        commit_valid = 1'b0;
        ren_valid    = 1'b1;
        ren_areg     = 6'd7;
        #1;
        n_vec++;
        if (ren_ready !== 1'b1 || ren_preg !== 6'd5 || ren_old !== 6'd7) begin
            n_err++;
            $display("FAIL recycle_alloc: got rdy=%0b preg=%0d old=%0d want 1 5 7", ren_ready, ren_preg, ren_old);
        end
        step();
        ren_valid = 1'b0;
        n_vec++;
        if (rat_write !== 1'b1 || rat_src !== 6'd7 || rat_dst !== 6'd5) begin
            n_err++;
            $display("FAIL recycle_write: got wr=%0b %0d->%0d want 1 7->5", rat_write, rat_src, rat_dst);
        end
        step();
        #1;
        n_vec++;
        if (ren_ready !== 1'b0) begin
            n_err++;
            $display("FAIL recycle_empty: got rdy=%0b want 0", ren_ready);
        end
    endtask

    task automatic test_simultaneous();
        commit_valid = 1'b1;
        commit_preg  = 6'd6;
        step();
        commit_preg  = 6'd9;
        ren_valid    = 1'b1;
        ren_areg     = 6'd8;
        #1;
        n_vec++;
        if (ren_ready !== 1'b1 || ren_preg !== 6'd6) begin
            n_err++;
            $display("FAIL simul_alloc: got rdy=%0b preg=%0d want 1 6", ren_ready, ren_preg);
        end
        step();
        commit_valid = 1'b0;
        ren_valid    = 1'b0;
        n_vec++;
        if (rat_write !== 1'b1 || rat_src !== 6'd8 || rat_dst !== 6'd6) begin
            n_err++;
            $display("FAIL simul_write: got wr=%0b %0d->%0d want 1 8->6", rat_write, rat_src, rat_dst);
        end
        step();
        ren_valid = 1'b1;
        #1;
        n_vec++;
        if (ren_ready !== 1'b1 || ren_preg !== 6'd9 || ren_old !== 6'd6) begin
            n_err++;
            $display("FAIL simul_next: got rdy=%0b preg=%0d old=%0d want 1 9 6", ren_ready, ren_preg, ren_old);
        end
        step();
        ren_valid = 1'b0;
        n_vec++;
        if (rat_write !== 1'b1 || rat_dst !== 6'd9) begin
            n_err++;
            $display("FAIL simul_write2: got wr=%0b dst=%0d want 1 9", rat_write, rat_dst);
        end
        step();
        #1;
        n_vec++;
        if (ren_ready !== 1'b0) begin
            n_err++;
            $display("FAIL simul_count: got rdy=%0b want 0", ren_ready);
        end
    endtask

    task automatic test_flush();
        rst_n = 1'b0;
        repeat (2) step();
        test_init_walk("init_flushed", 9);
        for (int k = 0; k < 3; k++) begin
            ren_valid = 1'b1;
            ren_areg  = 6'(k+1);
            #1;
            n_vec++;
            if (ren_ready !== 1'b1 || ren_preg !== 6'(35+k)) begin
                n_err++;
                $display("FAIL flush_pre %0d: got rdy=%0b preg=%0d want 1 %0d", k, ren_ready, ren_preg, 35+k);
            end
            step();
            ren_valid = 1'b0;
            step();
        end
        flush     = 1'b1;
        ren_valid = 1'b1;
        ren_areg  = 6'd4;
        #1;
        n_vec++;
        if (ren_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready: got %0b want 0", ren_ready);
        end
        step();
        flush     = 1'b0;
        ren_valid = 1'b0;
        n_vec++;
        if (rat_write !== 1'b0) begin
            n_err++;
            $display("FAIL flush_drop: got wr=%0b want 0", rat_write);
        end
        for (int i = 0; i < 35; i++) begin
            step();
            n_vec++;
            if (rat_write !== 1'b1 || rat_src !== 6'(i) || rat_dst !== rrat[i] || ren_ready !== 1'b0) begin
                n_err++;
                $display("FAIL recover_write %0d: got wr=%0b %0d->%0d rdy=%0b want 1 %0d->%0d 0",
                         i, rat_write, rat_src, rat_dst, ren_ready, i, rrat[i]);
            end
            step();
            n_vec++;
            if (rat_write !== 1'b0 || ren_ready !== (i == 34)) begin
                n_err++;
                $display("FAIL recover_gap %0d: got wr=%0b rdy=%0b want 0 %0b", i, rat_write, ren_ready, i == 34);
            end
        end
        ren_valid = 1'b1;
        ren_areg  = 6'd0;
        for (int k = 0; k < 29; k++) begin
            #1;
            n_vec++;
            if (ren_ready !== 1'b1 || ren_preg !== 6'(35+k) || ren_old !== ((k == 0) ? rrat[0] : 6'(34+k))) begin
                n_err++;
                $display("FAIL post_flush_alloc %0d: got rdy=%0b preg=%0d old=%0d want 1 %0d %0d",
                         k, ren_ready, ren_preg, ren_old, 35+k, (k == 0) ? rrat[0] : 6'(34+k));
            end
            step();
            step();
        end
        #1;
        n_vec++;
        if (ren_ready !== 1'b0) begin
            n_err++;
            $display("FAIL post_flush_count: got rdy=%0b want 0", ren_ready);
        end
        ren_valid = 1'b0;
    endtask

    task automatic test_reset_mid_recover();
        commit_valid = 1'b1;
        commit_preg  = 6'd7;
        step();
        commit_valid = 1'b0;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        repeat (20) step();
        step();
        n_vec++;
        if (rat_write !== 1'b1 || rat_src !== 6'd10) begin
            n_err++;
            $display("FAIL midrec_walk: got wr=%0b src=%0d want 1 10", rat_write, rat_src);
        end
        rst_n = 1'b0;
        step();
        n_vec++;
        if (rat_write !== 1'b0 || rat_src !== 6'd0 || rat_dst !== 6'd0 || ren_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midrec_reset: got wr=%0b src=%0d dst=%0d rdy=%0b want 0 0 0 0",
                     rat_write, rat_src, rat_dst, ren_ready);
        end
        test_init_walk("init_midrec", 0);
        ren_valid = 1'b1;
        ren_areg  = 6'd2;
        #1;
        n_vec++;
        if (ren_ready !== 1'b1 || ren_preg !== 6'd35) begin
            n_err++;
            $display("FAIL midrec_fl0: got rdy=%0b preg=%0d want 1 35", ren_ready, ren_preg);
        end
        step();
        ren_valid = 1'b0;
        step();
        #1;
        n_vec++;
        if (ren_preg !== 6'd36) begin
            n_err++;
            $display("FAIL midrec_fl1: got preg=%0d want 36", ren_preg);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        ren_valid    = 1'b0;
        ren_areg     = '0;
        commit_valid = 1'b0;
        commit_preg  = '0;
        flush        = 1'b0;
        for (int i = 0; i < NA; i++) begin
            frat[i] = '0;
            rrat[i] = 6'(63 - i);
        end
        test_reset();
        test_drain();
        test_recycle();
        test_simultaneous();
        test_flush();
        test_reset_mid_recover();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
